pc_unit: RTL and testbench



---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_ras.sv | 60 ++++++
 rtl/pc_unit.sv | 90 +++++++++
 tb/tb_pc_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program counter unit and its
// return-address stack.
package pc_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    INCREMENT = 2'd0,
    JUMP      = 2'd1,
    CALL      = 2'd2,
    RETURN    = 2'd3
  } pc_mode_e;

  localparam word PC_INIT_ADDR              = 32'h0000_0000;
  localparam int  INSTRUCTION_SIZE_IN_BYTES = 4;

endpackage : pc_pkg

// File: rtl/pc_ras.sv
// Circular return-address stack: a push past full overwrites the oldest entry,
// and the count saturates at RasDepth.
module pc_ras #(
  parameter int Width    = 32,
  parameter int RasDepth = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int PtrW = $clog2(RasDepth);
  localparam int CntW = $clog2(RasDepth + 1);

  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] mem_q [RasDepth];

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q != CntW'(RasDepth)) cnt_d = cnt_q + CntW'(1);
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (res) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; the count alone says which
  // entries are valid, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push && !res) mem_q[ptr_d] <= push_data;
  end

  assign top_data = mem_q[ptr_q];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(RasDepth));

endmodule : pc_ras

// File: rtl/pc_unit.sv
// Fetch program counter: increment, jump, call/return through a small RAS,
// trap redirect, hold on !enable, and rejection of misaligned targets.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               Width      = 32,
  parameter logic [Width-1:0] InitAddr   = Width'(PC_INIT_ADDR),
  parameter int               InstrBytes = INSTRUCTION_SIZE_IN_BYTES,
  parameter int               RasDepth   = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             enable,
  input  pc_mode_e         mode,
  input  logic [Width-1:0] jmp_addr,
  input  logic             trap,
  input  logic [Width-1:0] trap_addr,
  output logic [Width-1:0] pc,
  output logic [Width-1:0] pc_next,
  output logic             misaligned,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam logic [Width-1:0] AlignMask = Width'(InstrBytes - 1);
  localparam logic [Width-1:0] Step      = Width'(InstrBytes);

  logic [Width-1:0] pc_q, pc_d;
  logic             misaligned_q, misaligned_d;
  logic [Width-1:0] seq_pc;
  logic [Width-1:0] ras_top;
  logic             ras_push, ras_pop;

  assign seq_pc = pc_q + Step;

  always_comb begin
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    if (res) begin
      pc_d = InitAddr;
    end else if (trap) begin
      pc_d = trap_addr & ~AlignMask;
    end else if (enable) begin
      if (mode == INCREMENT) begin
        pc_d = seq_pc;
      end else if ((mode == RETURN) && !ras_empty) begin
        pc_d    = ras_top;
        ras_pop = 1'b1;
      end else if ((jmp_addr & AlignMask) != '0) begin
        // Rejected target: fall through sequentially and flag it.
        pc_d         = seq_pc;
        misaligned_d = 1'b1;
      end else begin
        pc_d     = jmp_addr;
        ras_push = (mode == CALL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      pc_q         <= InitAddr;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  pc_ras #(
    .Width    (Width),
    .RasDepth (RasDepth)
  ) u_ras (
    .clk       (clk),
    .res       (res),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc         = pc_q;
  assign pc_next    = pc_d;
  assign misaligned = misaligned_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a queue-based reference model checked on
// every falling edge, plus literal expectations along the directed sequence.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int RAS_DEPTH = 4;

  logic        clk;
  logic        res;
  logic        enable;
  pc_mode_e    mode;
  word         jmp_addr;
  logic        trap;
  word         trap_addr;
  word         pc;
  word         pc_next;
  logic        misaligned;
  logic        ras_empty;
  logic        ras_full;

  int errors = 0;
  int checks = 0;

  pc_unit #(
    .Width      (32),
    .InitAddr   (32'h0),
    .InstrBytes (4),
    .RasDepth   (RAS_DEPTH)
  ) dut (
    .clk        (clk),
    .res        (res),
    .enable     (enable),
    .mode       (mode),
    .jmp_addr   (jmp_addr),
    .trap       (trap),
    .trap_addr  (trap_addr),
    .pc         (pc),
    .pc_next    (pc_next),
    .misaligned (misaligned),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the RAS is a plain queue, newest entry at the back.
  word  m_pc;
  logic m_mis;
  bit   m_valid = 0;
  word  ras_q[$];

  // op: 0 none, 1 push, 2 pop, 3 reset
  function automatic void model_eval(output word npc, output logic nmis, output int op);
    npc  = m_pc;
    nmis = 1'b0;
    op   = 0;
    if (res) begin
      npc = 32'h0;
      op  = 3;
    end else if (trap) begin
      npc = {trap_addr[31:2], 2'b00};
    end else if (enable) begin
      if (mode == INCREMENT) begin
        npc = m_pc + 32'd4;
      end else if (mode == RETURN && ras_q.size() != 0) begin
        npc = ras_q[$];
        op  = 2;
      end else if (jmp_addr[1:0] != 2'b00) begin
        npc  = m_pc + 32'd4;
        nmis = 1'b1;
      end else begin
        npc = jmp_addr;
        if (mode == CALL) op = 1;
      end
    end
  endfunction

  always @(posedge clk) begin
    word  npc;
    logic nmis;
    int   op;
    model_eval(npc, nmis, op);
    case (op)
      1: begin
        ras_q.push_back(m_pc + 32'd4);
        if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
      end
      2: void'(ras_q.pop_back());
      3: ras_q.delete();
      default: ;
    endcase
    if (op == 3) m_valid = 1;
    m_pc  = npc;
    m_mis = nmis;
  end

  bit  have_prev = 0;
  word prev_pc_next;

  always @(negedge clk) begin
    word  npc;
    logic nmis;
    int   op;
    if (m_valid) begin
      model_eval(npc, nmis, op);
      check("model_pc", pc, m_pc);
      check("model_misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      check("model_ras_empty", {31'b0, ras_empty}, {31'b0, ras_q.size() == 0});
      check("model_ras_full", {31'b0, ras_full}, {31'b0, ras_q.size() == RAS_DEPTH});
      check("model_pc_next", pc_next, npc);
      if (have_prev) check("pc_follows_pc_next", pc, prev_pc_next);
      prev_pc_next = pc_next;
      have_prev    = 1;
    end
  end

  // Drives one cycle's inputs, waits for the edge, returns just after it.
  task automatic apply(input logic r, input logic en, input pc_mode_e md, input word ja,
                       input logic tr = 1'b0, input word ta = 32'h0);
    res       = r;
    enable    = en;
    mode      = md;
    jmp_addr  = ja;
    trap      = tr;
    trap_addr = ta;
    @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b1; enable = 1'b0; mode = INCREMENT; jmp_addr = '0; trap = 1'b0; trap_addr = '0;

    apply(1, 0, INCREMENT, 0);
    check("reset_pc", pc, 32'h0);
    check("reset_ras_empty", {31'b0, ras_empty}, 32'd1);
    check("reset_misaligned", {31'b0, misaligned}, 32'd0);

    for (int i = 1; i <= 3; i++) begin
      apply(0, 1, INCREMENT, 0);
      check("inc_pc", pc, 32'(i * 4));
    end
    apply(1, 1, INCREMENT, 0);
    check("midrun_reset_pc", pc, 32'h0);

    apply(0, 1, JUMP, 32'h100);
    check("jump_pc", pc, 32'h100);
    apply(0, 1, CALL, 32'h200);
    check("call_pc", pc, 32'h200);
    check("call_ras_nonempty", {31'b0, ras_empty}, 32'd0);
    apply(0, 1, RETURN, 32'hDEAD_BEE0);
    check("return_pc", pc, 32'h104);
    check("return_ras_empty", {31'b0, ras_empty}, 32'd1);

    // Five calls into a four-deep stack: the first return address is lost.
    apply(0, 1, JUMP, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      apply(0, 1, CALL, 32'(i * 16));
      check("chain_call_pc", pc, 32'(i * 16));
      if (i == 4) check("full_after_4", {31'b0, ras_full}, 32'd1);
    end
    check("full_after_5", {31'b0, ras_full}, 32'd1);
    for (int i = 4; i >= 1; i--) begin
      apply(0, 1, RETURN, 32'h900);
      check("chain_return_pc", pc, 32'(i * 16 + 4));
    end
    apply(0, 1, RETURN, 32'h900);
    check("empty_return_pc", pc, 32'h900);
    apply(0, 1, RETURN, 32'h901);
    check("empty_return_misaligned_pc", pc, 32'h904);
    check("empty_return_misaligned", {31'b0, misaligned}, 32'd1);

    apply(0, 1, JUMP, 32'h50);
    apply(0, 1, JUMP, 32'h202);
    check("misjump_pc", pc, 32'h54);
    check("misjump_flag", {31'b0, misaligned}, 32'd1);
    apply(0, 1, INCREMENT, 0);
    check("misjump_flag_clears", {31'b0, misaligned}, 32'd0);
    check("after_misjump_pc", pc, 32'h58);
    apply(0, 1, CALL, 32'h300);
    apply(0, 1, CALL, 32'h3);
    check("miscall_pc", pc, 32'h304);
    check("miscall_flag", {31'b0, misaligned}, 32'd1);
    check("miscall_no_push_full", {31'b0, ras_full}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      apply(0, 0, JUMP, 32'h800);
      check("hold_pc", pc, 32'h304);
    end
    check("hold_clears_flag", {31'b0, misaligned}, 32'd0);
    apply(0, 0, JUMP, 32'h800, 1, 32'h1007);
    check("trap_pc", pc, 32'h1004);
    check("trap_ras_kept", {31'b0, ras_empty}, 32'd0);
    apply(0, 1, RETURN, 32'h900);
    check("return_after_trap_pc", pc, 32'h5C);

    apply(0, 1, JUMP, 32'hFFFF_FFFC);
    apply(0, 1, INCREMENT, 0);
    check("wrap_pc", pc, 32'h0);
    apply(0, 1, CALL, 32'h40, 1, 32'h2000);
    check("trap_beats_call_pc", pc, 32'h2000);
    check("trap_beats_call_ras", {31'b0, ras_empty}, 32'd1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_unit
